d2l_feeder: RTL



---
 rtl/d2l_pkg.sv | 15 +
 rtl/d2l_fifo.sv | 62 ++++++
 rtl/d2l_feeder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/d2l_pkg.sv
// Shared widths and FSM state encoding for the D2L feeder.
package d2l_pkg;

    localparam int WORD_W = 64;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        WAIT_CLR,
        RESULT
    } state_t;

endpackage

// File: rtl/d2l_fifo.sv
// Synchronous FIFO with registered read pointer and wrap-bit full/empty flags.
// The head word is presented combinationally on rdata; there is no write-to-read
// bypass, so a word pushed into an empty FIFO is visible after the push edge.
module d2l_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_q[AW-1:0]];

    // Advance each pointer independently so a simultaneous push and pop both land.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) begin
            wr_d = wr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rd_d = rd_q + (AW+1)'(1);
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/d2l_feeder.sv
// Feeds buffered 64-bit words to a D2L block one at a time, waits for DONE
// (or a timeout), compares the returned word against the one sent, and hands
// the result downstream with pass/fail tallies.
module d2l_feeder
    import d2l_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    output logic        d2l_out_en,
    output logic [63:0] d2l_data_in,
    input  logic        d2l_done,
    input  logic [63:0] d2l_data_out,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [63:0] r_data,
    output logic        r_match,
    output logic        r_timeout,
    output logic [15:0] pass_cnt,
    output logic [15:0] fail_cnt,
    output logic        busy
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] data_in_q, data_in_d;
    logic [WORD_W-1:0] r_data_q, r_data_d;
    logic              r_match_q, r_match_d;
    logic              r_timeout_q, r_timeout_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [CNT_W-1:0]  pass_q, pass_d;
    logic [CNT_W-1:0]  fail_q, fail_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic [WORD_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign s_ready   = !rst && !fifo_full;
    assign fifo_push = s_valid && s_ready;

    d2l_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (s_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state, capture and tally logic; every register holds unless its state acts.
    always_comb begin
        state_d     = state_q;
        data_in_d   = data_in_q;
        r_data_d    = r_data_q;
        r_match_d   = r_match_q;
        r_timeout_d = r_timeout_q;
        tmo_d       = tmo_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        fifo_pop    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    data_in_d = fifo_rdata;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                tmo_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // DONE wins over a timeout landing in the same cycle.
                if (d2l_done) begin
                    r_data_d    = d2l_data_out;
                    r_match_d   = (d2l_data_out == data_in_q);
                    r_timeout_d = 1'b0;
                    state_d     = WAIT_CLR;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    r_data_d    = '0;
                    r_match_d   = 1'b0;
                    r_timeout_d = 1'b1;
                    state_d     = RESULT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WAIT_CLR: begin
                // Let DONE fall first so it cannot complete the following launch.
                if (!d2l_done) begin
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (r_ready) begin
                    if (r_match_q) begin
                        pass_d = sat_inc(pass_q);
                    end else begin
                        fail_d = sat_inc(fail_q);
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_in_q   <= '0;
            r_data_q    <= '0;
            r_match_q   <= 1'b0;
            r_timeout_q <= 1'b0;
            tmo_q       <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
        end else begin
            state_q     <= state_d;
            data_in_q   <= data_in_d;
            r_data_q    <= r_data_d;
            r_match_q   <= r_match_d;
            r_timeout_q <= r_timeout_d;
            tmo_q       <= tmo_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
        end
    end

    assign d2l_out_en  = (state_q == LAUNCH);
    assign d2l_data_in = data_in_q;
    assign r_valid     = (state_q == RESULT);
    assign r_data      = r_data_q;
    assign r_match     = r_match_q;
    assign r_timeout   = r_timeout_q;
    assign pass_cnt    = pass_q;
    assign fail_cnt    = fail_q;
    assign busy        = (state_q != IDLE);

endmodule
